// File: rtl/write_back_unit_pkg.sv
// Shared types for the write-back stage.
//   reg_index_t     : GPR index (5 bit)
//   gpr_wr_entry_t  : one buffered GPR write {valid, dest, data}
//   wb_state_t      : sleep sequencer states
//   cr_compare_field: builds a {LT,GT,EQ,SO} CR field from a signed result
package write_back_unit_pkg;

  localparam int CR_FIELD_W    = 4;
  localparam int NUM_CR_FIELDS = 8;

  typedef logic [4:0] reg_index_t;

  typedef struct packed {
    logic        valid;
    reg_index_t  dest;
    logic [31:0] data;
  } gpr_wr_entry_t;

  typedef enum logic [1:0] {
    WB_RUN   = 2'd0,
    WB_DRAIN = 2'd1,
    WB_SLEEP = 2'd2
  } wb_state_t;

  function automatic logic [CR_FIELD_W-1:0] cr_compare_field(input logic [31:0] res,
                                                             input logic        so);
    logic lt;
    logic eq;
    lt = res[31];
    eq = (res == 32'd0);
    return {lt, !lt && !eq, eq, so};
  endfunction

endpackage

// File: rtl/write_back_unit_if.sv
// Bundle of all write-back controls, data sources and commit outputs.
//   slave  : the write-back unit (controls/data in, commit strobes out)
//   master : the driving pipeline / environment
// Handshake: there is no valid/ready pair here. Every request (gpr_wr_*,
// record_*, spr/msr_we, sleep) is a single-cycle strobe that takes effect
// only in a cycle where en=1; the unit never back-pressures an individual
// strobe, and stall is an advisory "work still pending" indication.
interface write_back_unit_if;
  import write_back_unit_pkg::*;

  logic        en;
  reg_index_t  wb_gpr_dest_alu;
  reg_index_t  wb_gpr_dest_mem;
  logic        wb_gpr_wr_alu;
  logic        wb_gpr_wr_mem;
  logic        wb_wr_cr;
  logic [7:0]  wb_record_cr;
  logic        wb_record_ca;
  logic        wb_record_ov;
  logic        wb_spr_we;
  logic [9:0]  wb_spr_sel;
  logic        wb_msr_we;
  logic        wb_sleep;
  logic        dis_sleep;
  logic [31:0] alu_res;
  logic [31:0] mem_res;
  logic [31:0] alu_cr_in;
  logic        alu_ca;
  logic        alu_ov;
  logic        wakeup;

  logic        gpr_we;
  reg_index_t  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [31:0] cr;
  logic        xer_so;
  logic        xer_ca;
  logic        xer_ov;
  logic        spr_we_o;
  logic [9:0]  spr_sel_o;
  logic [31:0] spr_wdata;
  logic        msr_we_o;
  logic [31:0] msr_wdata;
  logic        stall;
  logic        sleeping;
  logic        overflow_err;
  wb_state_t   dbg_state;
  logic        dbg_fifo_full;

  modport slave (
    input  en, wb_gpr_dest_alu, wb_gpr_dest_mem, wb_gpr_wr_alu, wb_gpr_wr_mem,
           wb_wr_cr, wb_record_cr, wb_record_ca, wb_record_ov, wb_spr_we,
           wb_spr_sel, wb_msr_we, wb_sleep, dis_sleep, alu_res, mem_res,
           alu_cr_in, alu_ca, alu_ov, wakeup,
    output gpr_we, gpr_waddr, gpr_wdata, cr, xer_so, xer_ca, xer_ov, spr_we_o,
           spr_sel_o, spr_wdata, msr_we_o, msr_wdata, stall, sleeping,
           overflow_err, dbg_state, dbg_fifo_full
  );

  modport master (
    output en, wb_gpr_dest_alu, wb_gpr_dest_mem, wb_gpr_wr_alu, wb_gpr_wr_mem,
           wb_wr_cr, wb_record_cr, wb_record_ca, wb_record_ov, wb_spr_we,
           wb_spr_sel, wb_msr_we, wb_sleep, dis_sleep, alu_res, mem_res,
           alu_cr_in, alu_ca, alu_ov, wakeup,
    input  gpr_we, gpr_waddr, gpr_wdata, cr, xer_so, xer_ca, xer_ov, spr_we_o,
           spr_sel_o, spr_wdata, msr_we_o, msr_wdata, stall, sleeping,
           overflow_err, dbg_state, dbg_fifo_full
  );

endinterface

// File: rtl/write_back_unit_gpr_wr_fifo.sv
// gpr_wr_fifo: 2-entry buffer for load results that lost the GPR port.
//   push/push_entry : append an entry (dropped, push_dropped=1, if no room)
//   pop             : remove the head
//   kill_en/dest    : remove every stored entry whose dest matches
//   head            : oldest entry; count/count_next: occupancy now / after edge
//   full            : both slots occupied
// Entries are kept packed toward slot0, so slot0 is always the head. A killed
// entry is removed immediately, so it never occupies a port slot later.
module gpr_wr_fifo
  import write_back_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  gpr_wr_entry_t push_entry,
  input  logic          pop,
  input  logic          kill_en,
  input  reg_index_t    kill_dest,
  output gpr_wr_entry_t head,
  output logic [1:0]    count,
  output logic [1:0]    count_next,
  output logic          full,
  output logic          push_dropped
);

  gpr_wr_entry_t slot0_q, slot0_d, slot1_q, slot1_d;
  gpr_wr_entry_t surv0, surv1, rem0, rem1;
  logic          keep0, keep1;

  always_comb begin
    // 1) kill, 2) compact survivors, 3) pop, 4) push into the first free slot.
    keep0 = slot0_q.valid && !(kill_en && (slot0_q.dest == kill_dest));
    keep1 = slot1_q.valid && !(kill_en && (slot1_q.dest == kill_dest));

    surv0 = '0;
    surv1 = '0;
    if (keep0) begin
      surv0 = slot0_q;
      if (keep1) surv1 = slot1_q;
    end else if (keep1) begin
      surv0 = slot1_q;
    end

    rem0 = surv0;
    rem1 = surv1;
    if (pop) begin
      rem0 = surv1;
      rem1 = '0;
    end

    slot0_d      = rem0;
    slot1_d      = rem1;
    push_dropped = 1'b0;
    if (push) begin
      if (!rem0.valid) begin
        slot0_d       = push_entry;
        slot0_d.valid = 1'b1;
      end else if (!rem1.valid) begin
        slot1_d       = push_entry;
        slot1_d.valid = 1'b1;
      end else begin
        push_dropped = 1'b1;
      end
    end

    count_next = {slot1_d.valid, slot0_d.valid & ~slot1_d.valid};
  end

  assign head  = slot0_q;
  assign count = {slot1_q.valid, slot0_q.valid & ~slot1_q.valid};
  assign full  = slot1_q.valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/write_back_unit.sv
// write_back_unit: final pipeline stage. Arbitrates the single GPR write port
// between ALU and load results (buffering colliding loads), maintains CR and
// XER, forwards SPR/MSR write strobes and sequences RUN -> DRAIN -> SLEEP.
//   clk, reset (synchronous, active-low)
//   bus : write_back_unit_if.slave carrying all controls, data and outputs
// Every output is a flop; inputs sampled at an edge show up right after it.
module write_back_unit
  import write_back_unit_pkg::*;
(
  input logic              clk,
  input logic              reset,
  write_back_unit_if.slave bus
);

  logic          alu_wr, mem_wr, same_dest, fifo_nonempty;
  logic          fifo_push, fifo_pop, push_dropped, fifo_full;
  logic [1:0]    fifo_count, fifo_count_next;
  gpr_wr_entry_t fifo_head, mem_entry;

  logic          gpr_we_q, gpr_we_d;
  reg_index_t    gpr_waddr_q, gpr_waddr_d;
  logic [31:0]   gpr_wdata_q, gpr_wdata_d;
  logic [31:0]   cr_q, cr_d;
  logic          xer_so_q, xer_so_d, xer_ca_q, xer_ca_d, xer_ov_q, xer_ov_d;
  logic          spr_we_q, spr_we_d, msr_we_q, msr_we_d;
  logic [9:0]    spr_sel_q, spr_sel_d;
  logic [31:0]   spr_wdata_q, spr_wdata_d, msr_wdata_q, msr_wdata_d;
  logic          stall_q, stall_d, sleeping_q, sleeping_d, overflow_q, overflow_d;
  wb_state_t     state_q, state_d;

  gpr_wr_fifo u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .push_entry   (mem_entry),
    .pop          (fifo_pop),
    .kill_en      (alu_wr),
    .kill_dest    (bus.wb_gpr_dest_alu),
    .head         (fifo_head),
    .count        (fifo_count),
    .count_next   (fifo_count_next),
    .full         (fifo_full),
    .push_dropped (push_dropped)
  );

  always_comb begin
    alu_wr        = bus.en && bus.wb_gpr_wr_alu;
    mem_wr        = bus.en && bus.wb_gpr_wr_mem;
    // Equal dest in one cycle: the load is the younger write, so it takes the
    // port. The ALU dest still kills older buffered entries to that register
    // (alu_wr drives kill_en) so they cannot overwrite the newer value later.
    same_dest     = alu_wr && mem_wr && (bus.wb_gpr_dest_alu == bus.wb_gpr_dest_mem);
    fifo_nonempty = fifo_head.valid;
    mem_entry     = '{valid: 1'b1, dest: bus.wb_gpr_dest_mem, data: bus.mem_res};
    fifo_push     = mem_wr && !same_dest && (alu_wr || fifo_nonempty);
    fifo_pop      = bus.en && !alu_wr && fifo_nonempty;

    gpr_we_d    = 1'b0;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    if (same_dest || (mem_wr && !alu_wr && !fifo_nonempty)) begin
      gpr_we_d    = 1'b1;
      gpr_waddr_d = bus.wb_gpr_dest_mem;
      gpr_wdata_d = bus.mem_res;
    end else if (alu_wr) begin
      gpr_we_d    = 1'b1;
      gpr_waddr_d = bus.wb_gpr_dest_alu;
      gpr_wdata_d = bus.alu_res;
    end else if (fifo_pop) begin
      gpr_we_d    = 1'b1;
      gpr_waddr_d = fifo_head.dest;
      gpr_wdata_d = fifo_head.data;
    end

    xer_so_d = xer_so_q;
    xer_ca_d = xer_ca_q;
    xer_ov_d = xer_ov_q;
    if (bus.en && bus.wb_record_ca) xer_ca_d = bus.alu_ca;
    if (bus.en && bus.wb_record_ov) begin
      xer_ov_d = bus.alu_ov;
      xer_so_d = xer_so_q | bus.alu_ov;
    end

    // Compare-style fields use the SO value that includes this op's overflow.
    cr_d = cr_q;
    if (bus.en) begin
      for (int i = 0; i < NUM_CR_FIELDS; i++) begin
        if (bus.wb_record_cr[i]) begin
          cr_d[i*CR_FIELD_W +: CR_FIELD_W] = bus.wb_wr_cr
            ? bus.alu_cr_in[i*CR_FIELD_W +: CR_FIELD_W]
            : cr_compare_field(bus.alu_res, xer_so_d);
        end
      end
    end

    spr_we_d    = bus.en && bus.wb_spr_we;
    msr_we_d    = bus.en && bus.wb_msr_we;
    spr_sel_d   = bus.en ? bus.wb_spr_sel : spr_sel_q;
    spr_wdata_d = bus.en ? bus.alu_res : spr_wdata_q;
    msr_wdata_d = bus.en ? bus.alu_res : msr_wdata_q;

    state_d = state_q;
    if (bus.en) begin
      unique case (state_q)
        WB_RUN:   if (bus.wb_sleep && !bus.dis_sleep) state_d = WB_DRAIN;
        WB_DRAIN: if (fifo_count == 2'd0) state_d = WB_SLEEP;
        WB_SLEEP: if (bus.wakeup) state_d = WB_RUN;
        default:  state_d = WB_RUN;
      endcase
    end

    stall_d    = (fifo_count_next != 2'd0) || (state_d != WB_RUN);
    sleeping_d = (state_d == WB_SLEEP);
    overflow_d = overflow_q | push_dropped;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
      cr_q        <= '0;
      xer_so_q    <= 1'b0;
      xer_ca_q    <= 1'b0;
      xer_ov_q    <= 1'b0;
      spr_we_q    <= 1'b0;
      spr_sel_q   <= '0;
      spr_wdata_q <= '0;
      msr_we_q    <= 1'b0;
      msr_wdata_q <= '0;
      stall_q     <= 1'b0;
      sleeping_q  <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= WB_RUN;
    end else begin
      gpr_we_q    <= gpr_we_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
      cr_q        <= cr_d;
      xer_so_q    <= xer_so_d;
      xer_ca_q    <= xer_ca_d;
      xer_ov_q    <= xer_ov_d;
      spr_we_q    <= spr_we_d;
      spr_sel_q   <= spr_sel_d;
      spr_wdata_q <= spr_wdata_d;
      msr_we_q    <= msr_we_d;
      msr_wdata_q <= msr_wdata_d;
      stall_q     <= stall_d;
      sleeping_q  <= sleeping_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  assign bus.gpr_we        = gpr_we_q;
  assign bus.gpr_waddr     = gpr_waddr_q;
  assign bus.gpr_wdata     = gpr_wdata_q;
  assign bus.cr            = cr_q;
  assign bus.xer_so        = xer_so_q;
  assign bus.xer_ca        = xer_ca_q;
  assign bus.xer_ov        = xer_ov_q;
  assign bus.spr_we_o      = spr_we_q;
  assign bus.spr_sel_o     = spr_sel_q;
  assign bus.spr_wdata     = spr_wdata_q;
  assign bus.msr_we_o      = msr_we_q;
  assign bus.msr_wdata     = msr_wdata_q;
  assign bus.stall         = stall_q;
  assign bus.sleeping      = sleeping_q;
  assign bus.overflow_err  = overflow_q;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_fifo_full = fifo_full;

endmodule

// File: tb/tb_write_back_unit.sv
// Self-checking bench for write_back_unit: table-driven GPR and CR/XER/SPR
// vectors plus hand-written sleep, overflow and reset-mid-drain sequences.
module tb_write_back_unit;
  import write_back_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  write_back_unit_if bus ();

  write_back_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [36:0] exp_q[$];  // expected GPR port writes {addr, data}, in order

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.en              = 1'b1;
    bus.wb_gpr_dest_alu = '0;
    bus.wb_gpr_dest_mem = '0;
    bus.wb_gpr_wr_alu   = 1'b0;
    bus.wb_gpr_wr_mem   = 1'b0;
    bus.wb_wr_cr        = 1'b0;
    bus.wb_record_cr    = '0;
    bus.wb_record_ca    = 1'b0;
    bus.wb_record_ov    = 1'b0;
    bus.wb_spr_we       = 1'b0;
    bus.wb_spr_sel      = '0;
    bus.wb_msr_we       = 1'b0;
    bus.wb_sleep        = 1'b0;
    bus.dis_sleep       = 1'b0;
    bus.alu_res         = '0;
    bus.mem_res         = '0;
    bus.alu_cr_in       = '0;
    bus.alu_ca          = 1'b0;
    bus.alu_ov          = 1'b0;
    bus.wakeup          = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic gpr_ops(input logic aw, input logic [4:0] ad, input logic [31:0] ar,
                         input logic mw, input logic [4:0] md, input logic [31:0] mr);
    bus.wb_gpr_wr_alu   = aw;
    bus.wb_gpr_dest_alu = ad;
    bus.alu_res         = ar;
    bus.wb_gpr_wr_mem   = mw;
    bus.wb_gpr_dest_mem = md;
    bus.mem_res         = mr;
  endtask

  // One clock: queue the expected port write, then check what the port did.
  task automatic tick(input string nm, input logic e_we, input logic [4:0] e_addr,
                      input logic [31:0] e_data);
    logic [36:0] got;
    if (e_we) exp_q.push_back({e_addr, e_data});
    @(posedge clk);
    #1;
    chk({nm, ".we"}, 32'(bus.gpr_we), 32'(e_we));
    if (bus.gpr_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s.write: got r%0d=%h expected no write", nm, bus.gpr_waddr, bus.gpr_wdata);
      end else begin
        got = exp_q.pop_front();
        chk({nm, ".addr"}, 32'(bus.gpr_waddr), 32'(got[36:32]));
        chk({nm, ".data"}, bus.gpr_wdata, got[31:0]);
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic        en;
    logic        alu_wr;
    logic [4:0]  alu_dest;
    logic [31:0] alu_res;
    logic        mem_wr;
    logic [4:0]  mem_dest;
    logic [31:0] mem_res;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
  } gpr_vec_t;

  typedef struct {
    logic        en;
    logic        wr_cr;
    logic [7:0]  rec_cr;
    logic [31:0] cr_in;
    logic [31:0] res;
    logic        rec_ca;
    logic        ca;
    logic        rec_ov;
    logic        ov;
    logic        spr_we;
    logic [9:0]  spr_sel;
    logic        msr_we;
    logic [31:0] e_cr;
    logic        e_so;
    logic        e_ca;
    logic        e_ov;
    logic        e_spr_we;
    logic        e_msr_we;
  } cr_vec_t;

  gpr_vec_t gv[21];
  cr_vec_t  cv[8];

  initial begin
    // en, alu(wr,dest,res), mem(wr,dest,res), expected(we,addr,data,stall)
    gv[0]  = '{1'b1, 1'b1, 5'd3, 32'h5,   1'b1, 5'd4,  32'h7,  1'b1, 5'd3,  32'h5,   1'b1};
    gv[1]  = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 5'd4,  32'h7,   1'b0};
    gv[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b1, 5'd6,  32'h66, 1'b1, 5'd6,  32'h66,  1'b0};
    gv[3]  = '{1'b1, 1'b1, 5'd1, 32'h11,  1'b1, 5'd4,  32'h44, 1'b1, 5'd1,  32'h11,  1'b1};
    gv[4]  = '{1'b1, 1'b1, 5'd4, 32'h9,   1'b0, 5'd0,  32'h0,  1'b1, 5'd4,  32'h9,   1'b0};
    gv[5]  = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,   1'b0};
    gv[6]  = '{1'b1, 1'b1, 5'd7, 32'h77,  1'b1, 5'd7,  32'h70, 1'b1, 5'd7,  32'h70,  1'b0};
    gv[7]  = '{1'b1, 1'b1, 5'd2, 32'h22,  1'b1, 5'd8,  32'h88, 1'b1, 5'd2,  32'h22,  1'b1};
    gv[8]  = '{1'b1, 1'b1, 5'd9, 32'h99,  1'b1, 5'd10, 32'hAA, 1'b1, 5'd9,  32'h99,  1'b1};
    gv[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 5'd8,  32'h88,  1'b1};
    gv[10] = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b1, 5'd12, 32'hCC, 1'b1, 5'd10, 32'hAA,  1'b1};
    gv[11] = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 5'd12, 32'hCC,  1'b0};
    gv[12] = '{1'b0, 1'b1, 5'd5, 32'h55,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,   1'b0};
    gv[13] = '{1'b1, 1'b1, 5'd1, 32'h1,   1'b1, 5'd2,  32'h2,  1'b1, 5'd1,  32'h1,   1'b1};
    gv[14] = '{1'b0, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,   1'b1};
    gv[15] = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 5'd2,  32'h2,   1'b0};
    gv[16] = '{1'b1, 1'b1, 5'd1, 32'h10,  1'b1, 5'd2,  32'h20, 1'b1, 5'd1,  32'h10,  1'b1};
    gv[17] = '{1'b1, 1'b1, 5'd3, 32'h30,  1'b1, 5'd4,  32'h40, 1'b1, 5'd3,  32'h30,  1'b1};
    gv[18] = '{1'b1, 1'b1, 5'd2, 32'h200, 1'b0, 5'd0,  32'h0,  1'b1, 5'd2,  32'h200, 1'b1};
    gv[19] = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 5'd4,  32'h40,  1'b0};
    gv[20] = '{1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,   1'b0};

    // en, wr_cr, rec_cr, cr_in, res, rec_ca, ca, rec_ov, ov, spr_we, spr_sel, msr_we,
    // expected cr, so, ca, ov, spr_we, msr_we
    cv[0] = '{1'b1, 1'b0, 8'h80, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h0, 1'b0,
              32'h9000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[1] = '{1'b1, 1'b0, 8'h01, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0, 1'b0,
              32'h9000_0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[2] = '{1'b1, 1'b1, 8'h24, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0,
              32'h9030_0603, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[3] = '{1'b1, 1'b0, 8'h40, 32'h0, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0,
              32'h9530_0603, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[4] = '{1'b0, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h3, 1'b1,
              32'h9530_0603, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[5] = '{1'b1, 1'b0, 8'h00, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h1A5, 1'b1,
              32'h9530_0603, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    cv[6] = '{1'b1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0,
              32'h9530_0603, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[7] = '{1'b1, 1'b0, 8'h02, 32'h0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0, 1'b0,
              32'h9530_0653, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // ---------------- reset then idle ----------------
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    do_reset();
    chk("rst.gpr_we", 32'(bus.gpr_we), 32'd0);
    chk("rst.gpr_waddr", 32'(bus.gpr_waddr), 32'd0);
    chk("rst.gpr_wdata", bus.gpr_wdata, 32'd0);
    chk("rst.cr", bus.cr, 32'd0);
    chk("rst.xer", {29'd0, bus.xer_so, bus.xer_ca, bus.xer_ov}, 32'd0);
    chk("rst.spr", {bus.spr_we_o, bus.msr_we_o, bus.spr_sel_o}, 32'd0);
    chk("rst.spr_wdata", bus.spr_wdata, 32'd0);
    chk("rst.msr_wdata", bus.msr_wdata, 32'd0);
    chk("rst.flags", {29'd0, bus.stall, bus.sleeping, bus.overflow_err}, 32'd0);
    chk("rst.state", 32'(bus.dbg_state), 32'(WB_RUN));
    tick("idle", 1'b0, 5'd0, 32'd0);
    chk("idle.stall", 32'(bus.stall), 32'd0);
    chk("idle.cr", bus.cr, 32'd0);

    // ---------------- GPR arbitration table ----------------
    for (int i = 0; i < $size(gv); i++) begin
      clear_inputs();
      bus.en = gv[i].en;
      gpr_ops(gv[i].alu_wr, gv[i].alu_dest, gv[i].alu_res,
              gv[i].mem_wr, gv[i].mem_dest, gv[i].mem_res);
      tick($sformatf("gpr[%0d]", i), gv[i].e_we, gv[i].e_addr, gv[i].e_data);
      chk($sformatf("gpr[%0d].stall", i), 32'(bus.stall), 32'(gv[i].e_stall));
    end

    // ---------------- CR / XER / SPR table ----------------
    for (int i = 0; i < $size(cv); i++) begin
      clear_inputs();
      bus.en           = cv[i].en;
      bus.wb_wr_cr     = cv[i].wr_cr;
      bus.wb_record_cr = cv[i].rec_cr;
      bus.alu_cr_in    = cv[i].cr_in;
      bus.alu_res      = cv[i].res;
      bus.wb_record_ca = cv[i].rec_ca;
      bus.alu_ca       = cv[i].ca;
      bus.wb_record_ov = cv[i].rec_ov;
      bus.alu_ov       = cv[i].ov;
      bus.wb_spr_we    = cv[i].spr_we;
      bus.wb_spr_sel   = cv[i].spr_sel;
      bus.wb_msr_we    = cv[i].msr_we;
      tick($sformatf("cr[%0d]", i), 1'b0, 5'd0, 32'd0);
      chk($sformatf("cr[%0d].cr", i), bus.cr, cv[i].e_cr);
      chk($sformatf("cr[%0d].xer", i), {29'd0, bus.xer_so, bus.xer_ca, bus.xer_ov},
          {29'd0, cv[i].e_so, cv[i].e_ca, cv[i].e_ov});
      chk($sformatf("cr[%0d].spr_we", i), 32'(bus.spr_we_o), 32'(cv[i].e_spr_we));
      chk($sformatf("cr[%0d].msr_we", i), 32'(bus.msr_we_o), 32'(cv[i].e_msr_we));
      if (cv[i].e_spr_we) begin
        chk($sformatf("cr[%0d].spr_sel", i), 32'(bus.spr_sel_o), 32'(cv[i].spr_sel));
        chk($sformatf("cr[%0d].spr_wdata", i), bus.spr_wdata, cv[i].res);
        chk($sformatf("cr[%0d].msr_wdata", i), bus.msr_wdata, cv[i].res);
      end
    end

    // ---------------- sleep sequencing ----------------
    clear_inputs();
    gpr_ops(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    tick("slp.fill", 1'b1, 5'd1, 32'h1);
    clear_inputs();
    bus.wb_sleep = 1'b1;
    tick("slp.req", 1'b1, 5'd2, 32'h2);
    chk("slp.req.state", 32'(bus.dbg_state), 32'(WB_DRAIN));
    chk("slp.req.sleeping", 32'(bus.sleeping), 32'd0);
    chk("slp.req.stall", 32'(bus.stall), 32'd1);
    clear_inputs();
    tick("slp.enter", 1'b0, 5'd0, 32'd0);
    chk("slp.enter.state", 32'(bus.dbg_state), 32'(WB_SLEEP));
    chk("slp.enter.sleeping", 32'(bus.sleeping), 32'd1);
    chk("slp.enter.stall", 32'(bus.stall), 32'd1);
    tick("slp.hold", 1'b0, 5'd0, 32'd0);
    chk("slp.hold.sleeping", 32'(bus.sleeping), 32'd1);
    bus.wakeup = 1'b1;
    tick("slp.wake", 1'b0, 5'd0, 32'd0);
    chk("slp.wake.state", 32'(bus.dbg_state), 32'(WB_RUN));
    chk("slp.wake.sleeping", 32'(bus.sleeping), 32'd0);
    chk("slp.wake.stall", 32'(bus.stall), 32'd0);
    clear_inputs();
    bus.wb_sleep  = 1'b1;
    bus.dis_sleep = 1'b1;
    tick("slp.dis", 1'b0, 5'd0, 32'd0);
    chk("slp.dis.state", 32'(bus.dbg_state), 32'(WB_RUN));
    chk("slp.dis.stall", 32'(bus.stall), 32'd0);
    clear_inputs();
    bus.en       = 1'b0;
    bus.wb_sleep = 1'b1;
    tick("slp.en0", 1'b0, 5'd0, 32'd0);
    chk("slp.en0.state", 32'(bus.dbg_state), 32'(WB_RUN));

    // ---------------- overflow ----------------
    clear_inputs();
    gpr_ops(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    tick("ovf.p1", 1'b1, 5'd1, 32'h1);
    chk("ovf.p1.err", 32'(bus.overflow_err), 32'd0);
    gpr_ops(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    tick("ovf.p2", 1'b1, 5'd3, 32'h3);
    chk("ovf.p2.err", 32'(bus.overflow_err), 32'd0);
    chk("ovf.p2.full", 32'(bus.dbg_fifo_full), 32'd1);
    gpr_ops(1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6);
    tick("ovf.p3", 1'b1, 5'd5, 32'h5);
    chk("ovf.p3.err", 32'(bus.overflow_err), 32'd1);
    clear_inputs();
    tick("ovf.d1", 1'b1, 5'd2, 32'h2);
    tick("ovf.d2", 1'b1, 5'd4, 32'h4);
    chk("ovf.d2.stall", 32'(bus.stall), 32'd0);
    tick("ovf.d3", 1'b0, 5'd0, 32'd0);
    chk("ovf.sticky", 32'(bus.overflow_err), 32'd1);
    do_reset();
    chk("ovf.rst.err", 32'(bus.overflow_err), 32'd0);

    // ---------------- reset during drain ----------------
    clear_inputs();
    gpr_ops(1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20);
    tick("rdr.p1", 1'b1, 5'd1, 32'h10);
    gpr_ops(1'b1, 5'd3, 32'h30, 1'b1, 5'd4, 32'h40);
    tick("rdr.p2", 1'b1, 5'd3, 32'h30);
    clear_inputs();
    bus.wb_sleep = 1'b1;
    tick("rdr.drain", 1'b1, 5'd2, 32'h20);
    chk("rdr.drain.state", 32'(bus.dbg_state), 32'(WB_DRAIN));
    do_reset();
    chk("rdr.rst.we", 32'(bus.gpr_we), 32'd0);
    chk("rdr.rst.state", 32'(bus.dbg_state), 32'(WB_RUN));
    chk("rdr.rst.stall", 32'(bus.stall), 32'd0);
    tick("rdr.after", 1'b0, 5'd0, 32'd0);
    chk("rdr.after.stall", 32'(bus.stall), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
